photodiode_button_decode: RTL and testbench

PHOTODIODE_BUTTON_DECODE -- requirements
Module: photodiode_button_decode

---
 rtl/photodiode_button_decode.sv | 190 +++++++++++++++++++
 tb/tb_photodiode_button_decode.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/photodiode_button_decode.sv
// Five-channel photodiode button decoder: hysteresis thresholds, per-channel debounce, event queue.
// Define PD_EVENT_FIFO_EN for a 4-entry show-ahead event FIFO; otherwise a single holding register.
module photodiode_button_decode #(
    parameter int unsigned THR_ON     = 16,
    parameter int unsigned THR_OFF    = 32,
    parameter int unsigned DEB_FRAMES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PD_delays,
    input  logic [11:0] PD4_delay,
    input  logic        frame_strobe,
    output logic [4:0]  buttons,
    output logic        event_valid,
    output logic [3:0]  event_data,
    input  logic        event_ready,
    output logic        frame_done,
    output logic        overflow,
    output logic        missed_frame
);

    localparam logic [7:0] THR_ON_8  = 8'(THR_ON);
    localparam logic [7:0] THR_OFF_8 = 8'(THR_OFF);
    localparam logic [2:0] DEB_3     = 3'(DEB_FRAMES);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [4:0][7:0] snap_q, snap_d;
    logic [4:0][2:0] cnt_q, cnt_d;
    logic [4:0]      buttons_q, buttons_d;
    logic            frame_done_q, frame_done_d;
    logic            overflow_q, overflow_d;
    logic            missed_q, missed_d;

    logic            push, push_ok, pop;
    logic [3:0]      push_data;
    logic [7:0]      cur_val;
    logic            cur_btn, cand;
    logic [2:0]      cnt_inc;

`ifdef PD_EVENT_FIFO_EN
    logic [3:0][3:0] mem_q, mem_d;
    logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;

    assign event_valid = (count_q != 3'd0);
    assign event_data  = event_valid ? mem_q[rd_ptr_q] : 4'd0;
`else
    logic            hold_valid_q, hold_valid_d;
    logic [3:0]      hold_data_q, hold_data_d;

    assign event_valid = hold_valid_q;
    assign event_data  = hold_valid_q ? hold_data_q : 4'd0;
`endif

    // Low nibble of the channel-4 delay is below the comparison resolution.
    logic unused_pd4_lsbs;
    assign unused_pd4_lsbs = ^PD4_delay[3:0];

    assign pop          = event_valid && event_ready;
    assign buttons      = buttons_q;
    assign frame_done   = frame_done_q;
    assign overflow     = overflow_q;
    assign missed_frame = missed_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        snap_d       = snap_q;
        cnt_d        = cnt_q;
        buttons_d    = buttons_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        missed_d     = missed_q;
        push         = 1'b0;
        push_data    = 4'd0;
        cur_val      = snap_q[idx_q];
        cur_btn      = buttons_q[idx_q];
        cand         = cur_btn ? (cur_val > THR_OFF_8) : (cur_val < THR_ON_8);
        cnt_inc      = cnt_q[idx_q] + 3'd1;

        case (state_q)
            IDLE: begin
                if (frame_strobe) begin
                    snap_d[0] = PD_delays[7:0];
                    snap_d[1] = PD_delays[15:8];
                    snap_d[2] = PD_delays[23:16];
                    snap_d[3] = PD_delays[31:24];
                    snap_d[4] = PD4_delay[11:4];
                    idx_d     = 3'd0;
                    state_d   = SCAN;
                end
            end
            SCAN: begin
                if (frame_strobe) begin
                    missed_d = 1'b1;
                end
                if (!cand) begin
                    cnt_d[idx_q] = 3'd0;
                end else if (cnt_inc == DEB_3) begin
                    cnt_d[idx_q]     = 3'd0;
                    buttons_d[idx_q] = ~cur_btn;
                    push             = 1'b1;
                    push_data        = {~cur_btn, idx_q};
                end else begin
                    cnt_d[idx_q] = cnt_inc;
                end
                if (idx_q == 3'd4) begin
                    idx_d        = 3'd0;
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PD_EVENT_FIFO_EN
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push && ((count_q != 3'd4) || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, push_ok} - {2'b00, pop};
`else
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        push_ok      = push && (!hold_valid_q || pop);
        if (push_ok) begin
            hold_valid_d = 1'b1;
            hold_data_d  = push_data;
        end else if (pop) begin
            hold_valid_d = 1'b0;
        end
`endif
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 3'd0;
            snap_q       <= '0;
            cnt_q        <= '0;
            buttons_q    <= 5'd0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            missed_q     <= 1'b0;
`ifdef PD_EVENT_FIFO_EN
            mem_q        <= '0;
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
`else
            hold_valid_q <= 1'b0;
            hold_data_q  <= 4'd0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            snap_q       <= snap_d;
            cnt_q        <= cnt_d;
            buttons_q    <= buttons_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            missed_q     <= missed_d;
`ifdef PD_EVENT_FIFO_EN
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
`else
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
`endif
        end
    end

endmodule

// File: tb/tb_photodiode_button_decode.sv
// Directed testbench for photodiode_button_decode; expectations follow the PD_EVENT_FIFO_EN setting.
module tb_photodiode_button_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PD_delays;
    logic [11:0] PD4_delay;
    logic        frame_strobe;
    logic [4:0]  buttons;
    logic        event_valid;
    logic [3:0]  event_data;
    logic        event_ready;
    logic        frame_done;
    logic        overflow;
    logic        missed_frame;

    int tests = 0;
    int fails = 0;

`ifdef PD_EVENT_FIFO_EN
    localparam int QUEUE_DEPTH = 4;
`else
    localparam int QUEUE_DEPTH = 1;
`endif

    // Channel bytes are {ch3, ch2, ch1, ch0}; 8'hC8 = 200 is a neutral released level.
    localparam logic [31:0] PD_CH2_5    = 32'hC805C8C8;
    localparam logic [31:0] PD_HYST     = 32'hC820C810;
    localparam logic [31:0] PD_CH2_40   = 32'hC828C8C8;
    localparam logic [31:0] PD_CH1_0    = 32'hC8C800C8;
    localparam logic [31:0] PD_NEUTRAL  = 32'hC8C8C8C8;
    localparam logic [11:0] PD4_NEUTRAL = 12'hC80;

    photodiode_button_decode dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .PD_delays    (PD_delays),
        .PD4_delay    (PD4_delay),
        .frame_strobe (frame_strobe),
        .buttons      (buttons),
        .event_valid  (event_valid),
        .event_data   (event_data),
        .event_ready  (event_ready),
        .frame_done   (frame_done),
        .overflow     (overflow),
        .missed_frame (missed_frame)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete frame: strobe for one cycle, then wait until the scan is over and idle again.
    task automatic applyStimulus(input logic [31:0] pd, input logic [11:0] pd4);
        @(negedge clk);
        PD_delays    = pd;
        PD4_delay    = pd4;
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic popEvent();
        @(negedge clk);
        event_ready = 1'b1;
        @(negedge clk);
        event_ready = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_buttons"},     32'(buttons),      32'h0);
        checkOutput({tag, "_evvalid"},     32'(event_valid),  32'h0);
        checkOutput({tag, "_evdata"},      32'(event_data),   32'h0);
        checkOutput({tag, "_frame_done"},  32'(frame_done),   32'h0);
        checkOutput({tag, "_overflow"},    32'(overflow),     32'h0);
        checkOutput({tag, "_missed"},      32'(missed_frame), 32'h0);
    endtask

    initial begin
        rst_n        = 1'b0;
        frame_strobe = 1'b0;
        event_ready  = 1'b0;
        PD_delays    = 32'h0;
        PD4_delay    = 12'h0;

        doReset();
        checkResetState("reset");

        // ch2 = 5 for three frames; the third frame is stepped cycle by cycle.
        applyStimulus(PD_CH2_5, PD4_NEUTRAL);
        applyStimulus(PD_CH2_5, PD4_NEUTRAL);
        checkOutput("press_two_frames", 32'(buttons), 32'h00);
        @(negedge clk);
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
        @(negedge clk);
        checkOutput("press_t1", 32'(buttons), 32'h00);
        @(negedge clk);
        checkOutput("press_t2", 32'(buttons), 32'h00);
        @(negedge clk);
        checkOutput("press_t3_buttons", 32'(buttons), 32'h04);
        checkOutput("press_t3_valid", 32'(event_valid), 32'h1);
        checkOutput("press_event", 32'(event_data), 32'hA);
        @(negedge clk);
        checkOutput("frame_done_early", 32'(frame_done), 32'h0);
        @(negedge clk);
        checkOutput("frame_done_high", 32'(frame_done), 32'h1);
        @(negedge clk);
        checkOutput("frame_done_pulse", 32'(frame_done), 32'h0);
        popEvent();
        checkOutput("press_popped", 32'(event_valid), 32'h0);

        // ch2 held at THR_OFF and ch0 at THR_ON: both sit inside the hysteresis band.
        repeat (5) applyStimulus(PD_HYST, PD4_NEUTRAL);
        checkOutput("hyst_buttons", 32'(buttons), 32'h04);
        checkOutput("hyst_no_event", 32'(event_valid), 32'h0);
        applyStimulus(PD_CH2_40, PD4_NEUTRAL);
        applyStimulus(PD_CH2_40, PD4_NEUTRAL);
        checkOutput("release_two_frames", 32'(buttons), 32'h04);
        applyStimulus(PD_CH2_40, PD4_NEUTRAL);
        checkOutput("release_buttons", 32'(buttons), 32'h00);
        checkOutput("release_event", 32'(event_data), 32'h2);
        popEvent();

        // Second strobe two cycles into the scan must be ignored.
        doReset();
        @(negedge clk);
        PD_delays    = PD_CH1_0;
        PD4_delay    = PD4_NEUTRAL;
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
        @(negedge clk);
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
        checkOutput("missed_set", 32'(missed_frame), 32'h1);
        repeat (5) @(negedge clk);
        applyStimulus(PD_CH1_0, PD4_NEUTRAL);
        checkOutput("missed_not_counted", 32'(buttons), 32'h00);
        applyStimulus(PD_CH1_0, PD4_NEUTRAL);
        checkOutput("missed_press", 32'(buttons), 32'h02);
        checkOutput("missed_event", 32'(event_data), 32'h9);
        checkOutput("missed_sticky", 32'(missed_frame), 32'h1);

        // Channel 4 uses PD4_delay[11:4]; then reset lands in the middle of a scan.
        doReset();
        repeat (3) applyStimulus(PD_NEUTRAL, 12'h0F0);
        checkOutput("ch4_buttons", 32'(buttons), 32'h10);
        checkOutput("ch4_event", 32'(event_data), 32'hC);
        @(negedge clk);
        PD_delays    = 32'h0;
        PD4_delay    = 12'h0;
        frame_strobe = 1'b1;
        @(negedge clk);
        frame_strobe = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkResetState("midscan");
        repeat (7) @(negedge clk);
        checkOutput("midscan_no_update", 32'(buttons), 32'h00);
        checkOutput("midscan_no_event", 32'(event_valid), 32'h0);

        // Consumer always ready: each push meets a same-edge pop, nothing may be dropped.
        doReset();
        event_ready = 1'b1;
        repeat (3) applyStimulus(32'h0, 12'h0);
        event_ready = 1'b0;
        checkOutput("stream_buttons", 32'(buttons), 32'h1F);
        checkOutput("stream_overflow", 32'(overflow), 32'h0);
        checkOutput("stream_drained", 32'(event_valid), 32'h0);

        // Consumer stalled: five presses in one frame overrun the queue.
        doReset();
        repeat (3) applyStimulus(32'h0, 12'h0);
        checkOutput("ovf_buttons", 32'(buttons), 32'h1F);
        checkOutput("ovf_flag", 32'(overflow), 32'h1);
        checkOutput("ovf_valid", 32'(event_valid), 32'h1);
        repeat (2) @(negedge clk);
        checkOutput("ovf_stable", 32'(event_data), 32'h8);
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            checkOutput($sformatf("ovf_drain%0d", i), 32'(event_data), 32'h8 + 32'(i));
            popEvent();
        end
        checkOutput("ovf_empty", 32'(event_valid), 32'h0);
        checkOutput("ovf_sticky", 32'(overflow), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
